// File: rtl/jpeg_nbr_fetch.sv
// jpeg_nbr_fetch: walks a 16-row stripe column by column and presents mirrored left/same/right
// neighbourhood vectors to top_jpeg. Define NBR_FLGS_EN to also build the flag vector on flgs_s_o.

// One neighbourhood window (left/same/right columns) plus the column assembly shift register.
module jpeg_nbr_win #(
  parameter int N  = 16,
  parameter int SW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shift_en,
  input  logic            mirror_en,
  input  logic            cap_en,
  input  logic            fin_en,
  input  logic            fin_all,
  input  logic            fin_left,
  input  logic [SW-1:0]   d,
  output logic [N*SW-1:0] left,
  output logic [N*SW-1:0] sam,
  output logic [N*SW-1:0] right
);
  logic [(N-1)*SW-1:0] sh_q;
  logic [N*SW-1:0]     vec;

  // newest read lands at the top, so row 0 ends up in the low bits after N reads
  assign vec = {d, sh_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      left  <= '0;
      sam   <= '0;
      right <= '0;
    end else begin
      if (cap_en) sh_q <= vec[N*SW-1:SW];
      if (shift_en) begin
        left <= sam;
        sam  <= right;
      end else if (mirror_en) begin
        right <= left;
      end else if (fin_en) begin
        right <= vec;
        if (fin_all) begin
          left <= vec;
          sam  <= vec;
        end else if (fin_left) begin
          left <= vec;
        end
      end
    end
  end
endmodule

// state  | meaning
// IDLE   | waiting for start
// FETCH  | reading one column (17 cycles), or the one-cycle priming shift
// MIRROR | last column: right <- left, no RAM reads
// ISSUE  | holding vectors until noupdate_s permits update_s
// DONE   | one-cycle done pulse
module jpeg_nbr_fetch #(
  parameter int W  = 9,
  parameter int N  = 16,
  parameter int FW = 5,
  parameter int AW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic [AW-1:0]  stride,
  input  logic [9:0]     cols,
  input  logic [9:0]     row_base,
  output logic [AW-1:0]  ram_addr,
  input  logic [W-1:0]   ram_q,
  input  logic [FW-1:0]  flg_q,
  output logic [N*W-1:0] left_s_o,
  output logic [N*W-1:0] sam_s_o,
  output logic [N*W-1:0] right_s_o,
  output logic [N*FW-1:0] flgs_s_o,
  output logic           update_s,
  input  logic           noupdate_s,
  output logic [9:0]     row_ind,
  output logic [9:0]     col_ind,
  output logic           busy,
  output logic           done
);
  typedef enum logic [2:0] {IDLE, FETCH, MIRROR, ISSUE, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, col_base_q, stride_q;
  logic [9:0]    cols_q, c_q, row_q;
  logic [4:0]    cnt_q;
  logic          first_q, shift_q;
  logic          fetch_done, last_c, shift_en, mirror_en, cap_en, fin_all, fin_left;

  assign ram_addr = addr_q;
  assign row_ind  = row_q;
  assign col_ind  = c_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    update_s   = 1'b0;
    done       = 1'b0;
    fetch_done = (state_q == FETCH) && !shift_q && (cnt_q == 5'd16);
    last_c     = (c_q == cols_q - 10'd1);
    cap_en     = (state_q == FETCH) && !shift_q && (cnt_q != 5'd0);
    shift_en   = (state_q == FETCH) && shift_q;
    mirror_en  = (state_q == MIRROR);
    fin_all    = fetch_done && first_q && (cols_q == 10'd1);
    fin_left   = fetch_done && !first_q && (c_q == 10'd0);
    case (state_q)
      IDLE:   if (start) state_d = (cols == 10'd0) ? DONE : FETCH;
      FETCH:  if (fetch_done) state_d = (first_q && cols_q != 10'd1) ? FETCH : ISSUE;
      ISSUE: begin
        if (noupdate_s) begin
          update_s = 1'b1;
          if (last_c) begin
            state_d = DONE;
          end else begin
            shift_en = 1'b1;
            state_d  = (c_q + 10'd2 == cols_q) ? MIRROR : FETCH;
          end
        end
      end
      MIRROR: state_d = ISSUE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // addresses step by stride within a column; the next column's base is preloaded on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      col_base_q <= '0;
      stride_q   <= '0;
      cols_q     <= '0;
      c_q        <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          stride_q   <= stride;
          cols_q     <= cols;
          row_q      <= row_base;
          addr_q     <= base_addr;
          col_base_q <= base_addr;
          c_q        <= '0;
          cnt_q      <= '0;
          first_q    <= 1'b1;
          shift_q    <= 1'b0;
        end
        FETCH: begin
          if (shift_q) begin
            shift_q <= 1'b0;
          end else if (fetch_done) begin
            cnt_q      <= '0;
            col_base_q <= col_base_q + AW'(1);
            addr_q     <= col_base_q + AW'(1);
            first_q    <= 1'b0;
            shift_q    <= first_q && (cols_q != 10'd1);
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q < 5'd15) addr_q <= addr_q + stride_q;
          end
        end
        ISSUE: if (noupdate_s && !last_c) c_q <= c_q + 10'd1;
        default: ;
      endcase
    end
  end

  jpeg_nbr_win #(.N(N), .SW(W)) u_smp (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mirror_en(mirror_en), .cap_en(cap_en),
    .fin_en(fetch_done), .fin_all(fin_all), .fin_left(fin_left), .d(ram_q),
    .left(left_s_o), .sam(sam_s_o), .right(right_s_o)
  );

`ifdef NBR_FLGS_EN
  logic [N*FW-1:0] flg_left_unused, flg_right_unused;

  jpeg_nbr_win #(.N(N), .SW(FW)) u_flg (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mirror_en(mirror_en), .cap_en(cap_en),
    .fin_en(fetch_done), .fin_all(fin_all), .fin_left(fin_left), .d(flg_q),
    .left(flg_left_unused), .sam(flgs_s_o), .right(flg_right_unused)
  );
`else
  logic unused_flg;

  assign unused_flg = ^flg_q;
  assign flgs_s_o   = '0;
`endif
endmodule

// File: tb/tb_jpeg_nbr_fetch.sv
// Testbench for jpeg_nbr_fetch: directed and randomized stripes checked against a column-level model.
module tb_jpeg_nbr_fetch;
  localparam int W = 9, N = 16, FW = 5, AW = 10;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, noupdate_s = 1'b1;
  logic [AW-1:0]  base_addr = '0, stride = '0, ram_addr;
  logic [9:0]     cols = '0, row_base = '0, row_ind, col_ind;
  logic [W-1:0]   ram_q;
  logic [FW-1:0]  flg_q;
  logic [N*W-1:0] left_s_o, sam_s_o, right_s_o;
  logic [N*FW-1:0] flgs_s_o;
  logic           update_s, busy, done;

  logic [8:0] mem[1024];
  logic [4:0] fmem[1024];

  int n_assert = 0, n_fail = 0;

  jpeg_nbr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
    .cols(cols), .row_base(row_base), .ram_addr(ram_addr), .ram_q(ram_q), .flg_q(flg_q),
    .left_s_o(left_s_o), .sam_s_o(sam_s_o), .right_s_o(right_s_o), .flgs_s_o(flgs_s_o),
    .update_s(update_s), .noupdate_s(noupdate_s), .row_ind(row_ind), .col_ind(col_ind),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    flg_q <= fmem[ram_addr];
  end

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [N*W-1:0] col_vec(input int b, input int s, input int k);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[W*i +: W] = mem[(b + k + i*s) % 1024];
    return v;
  endfunction

  function automatic logic [N*FW-1:0] exp_flg(input int b, input int s, input int k);
    logic [N*FW-1:0] v;
    v = '0;
`ifdef NBR_FLGS_EN
    for (int i = 0; i < N; i++) v[FW*i +: FW] = fmem[(b + k + i*s) % 1024];
`endif
    return v;
  endfunction

  // mirror extension: column -1 reads as column 1, column cols reads as column cols-2
  function automatic int lft(input int c, input int nc);
    if (nc == 1) return 0;
    return (c == 0) ? 1 : c - 1;
  endfunction

  function automatic int rgt(input int c, input int nc);
    if (nc == 1) return 0;
    return (c == nc - 1) ? c - 1 : c + 1;
  endfunction

  task automatic check_pos(input string tag, input int b, input int s, input int c,
                           input int nc, input int rb);
    chk({tag, "_col_ind"}, col_ind, c);
    chk({tag, "_row_ind"}, row_ind, rb);
    chk({tag, "_left"}, left_s_o, col_vec(b, s, lft(c, nc)));
    chk({tag, "_sam"}, sam_s_o, col_vec(b, s, c));
    chk({tag, "_right"}, right_s_o, col_vec(b, s, rgt(c, nc)));
    chk({tag, "_flgs"}, flgs_s_o, exp_flg(b, s, c));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_left"}, left_s_o, 0);
    chk({tag, "_sam"}, sam_s_o, 0);
    chk({tag, "_right"}, right_s_o, 0);
    chk({tag, "_flgs"}, flgs_s_o, 0);
    chk({tag, "_row_ind"}, row_ind, 0);
    chk({tag, "_col_ind"}, col_ind, 0);
    chk({tag, "_update_s"}, update_s, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_stripe(input int b, input int s, input int nc, input int rb,
                            input int bp_col, input bit rnd);
    int cyc, nupd, last_upd, hold, budget;
    bit fin, want_upd;
    cyc = 0; nupd = 0; last_upd = -100; hold = 0; fin = 0; want_upd = 0;
    budget = 100 + 20*nc + (rnd ? 40*nc : 0) + (bp_col >= 0 ? 100 : 0);
    @(negedge clk);
    base_addr = AW'(b); stride = AW'(s); cols = 10'(nc); row_base = 10'(rb);
    start = 1'b1; noupdate_s = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rnd && nc > 0 && cyc == 5) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        cols = 10'($urandom_range(1, 8));
      end
      if (hold > 0) noupdate_s = 1'b0;
      else if (rnd) noupdate_s = 1'($urandom_range(0, 1));
      else noupdate_s = 1'b1;
      #1;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (hold > 0) begin
        chk("bp_no_update", update_s, 0);
        if (hold <= 50) begin
          chk("bp_frozen_col", col_ind, bp_col);
          chk("bp_frozen_sam", sam_s_o, col_vec(b, s, bp_col));
          chk("bp_frozen_left", left_s_o, col_vec(b, s, lft(bp_col, nc)));
          chk("bp_frozen_right", right_s_o, col_vec(b, s, rgt(bp_col, nc)));
        end
        hold--;
        if (hold == 0) want_upd = 1;
      end else if (want_upd) begin
        chk("bp_release_update", update_s, 1);
        want_upd = 0;
      end
      if (update_s) begin
        check_pos("upd", b, s, nupd, nc, rb);
        chk("no_back_to_back", (cyc - last_upd) >= 2, 1);
        if (nupd == 0 && !rnd && bp_col < 0 && nc >= 2) chk("first_latency", cyc, 36);
        if (bp_col >= 1 && nupd == bp_col - 1) hold = 68;
        last_upd = cyc;
        nupd++;
      end
      if (done) begin
        chk("update_count", nupd, nc);
        fin = 1;
      end
    end
    chk("stripe_finished", fin, 1);
    @(negedge clk);
    noupdate_s = 1'b1;
    #1;
    chk("done_single_pulse", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    for (int a = 0; a < 1024; a++) begin
      mem[a]  = 9'(a);
      fmem[a] = 5'(a);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_stripe(0, 8, 8, 0, -1, 0);
    run_stripe(0, 8, 8, 37, 3, 0);
    run_stripe(0, 8, 1, 5, -1, 0);
    run_stripe(0, 8, 0, 0, -1, 0);

    // reset while column 4 is being fetched (current column 3)
    @(negedge clk);
    base_addr = '0; stride = 10'd8; cols = 10'd8; row_base = 10'd9;
    start = 1'b1; noupdate_s = 1'b1;
    cnt = 0; seen = 0;
    while (!seen && cnt < 300) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      #1;
      if (update_s && col_ind == 10'd2) seen = 1;
    end
    chk("midrst_reached", seen, 1);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_stripe(0, 8, 8, 0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 1024; a++) begin
        mem[a]  = 9'($urandom);
        fmem[a] = 5'($urandom);
      end
      run_stripe($urandom_range(0, 1023), $urandom_range(1, 1023), $urandom_range(0, 7),
                 $urandom_range(0, 1023), -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
